// File: rtl/fifo_burst_pkg.sv
// Shared state encoding and counter sizing helper for the FIFO burst reader.
package fifo_burst_pkg;

   typedef enum logic [1:0] {IDLE, BURST, DRAIN} burst_state_e;

   localparam int unsigned SKID_ENTRIES = 2;

   // Bits needed to hold any value 0..max_val (at least one bit).
   function automatic int unsigned cnt_w(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/stream_skid2.sv
// Two-entry valid/ready skid buffer; entry 0 is always the head presented downstream.
module stream_skid2 #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic [1:0]   occ
);

   logic [W-1:0] ent0_q, ent0_d;
   logic [W-1:0] ent1_q, ent1_d;
   logic [1:0]   occ_q, occ_d;
   logic [1:0]   remain;
   logic         pop;

   // NOTE: every variable gets a default at the top of always_comb so no path leaves one unassigned (no latch).
   always_comb begin
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      pop    = (occ_q != 2'd0) && out_ready;
      remain = occ_q - 2'(pop);
      if (pop) begin
         ent0_d = ent1_q;
      end
      if (in_valid) begin
         if (remain == 2'd0) begin
            ent0_d = in_data;
         end else begin
            ent1_d = in_data;
         end
      end
      occ_d = remain + 2'(in_valid);
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         occ_q  <= 2'd0;
         // NOTE: data entries are reset too because the head drives m_data, which must read 0 out of reset.
         ent0_q <= '0;
         ent1_q <= '0;
      end else begin
         occ_q  <= occ_d;
         ent0_q <= ent0_d;
         ent1_q <= ent1_d;
      end
   end

   assign out_valid = (occ_q != 2'd0);
   assign out_data  = ent0_q;
   assign occ       = occ_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops a synchronous FIFO (1-cycle read latency) and emits fixed-length valid/ready bursts.
// Define FIFO_BURST_PARITY_EN to add the m_parity / parity_err_cnt parity sideband.
module fifo_burst_reader
   import fifo_burst_pkg::*;
#(
   parameter int unsigned width      = 16,
   parameter int unsigned BURST_LEN  = 4,
   parameter int unsigned SKID_DEPTH = SKID_ENTRIES
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             en,
   input  logic             fifo_empty,
   input  logic [width-1:0] fifo_data_out,
`ifdef FIFO_BURST_PARITY_EN
   input  logic             fifo_parity,
   output logic             m_parity,
   output logic [7:0]       parity_err_cnt,
`endif
   output logic             fifo_read,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [width-1:0] m_data,
   output logic             m_last,
   output logic             busy
);

   localparam int unsigned ISS_W = cnt_w(BURST_LEN);
   localparam int unsigned OUT_W = cnt_w(BURST_LEN - 1);
   localparam logic [ISS_W-1:0] ISS_FULL = ISS_W'(BURST_LEN);
   localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(BURST_LEN - 1);
   localparam logic [2:0]       SKID_CAP = 3'(SKID_DEPTH);
`ifdef FIFO_BURST_PARITY_EN
   localparam int unsigned EW = width + 2;
`else
   localparam int unsigned EW = width;
`endif

   burst_state_e     state_q, state_d;
   logic [ISS_W-1:0] iss_cnt_q, iss_cnt_d;
   logic [OUT_W-1:0] out_cnt_q, out_cnt_d;
   logic             inflight_q, inflight_d;
   logic [1:0]       occ;
   logic [EW-1:0]    cap_entry;
   logic [EW-1:0]    head;
   logic             beat_acc, last_acc, start_ok, can_take;

   // A beat leaving this cycle frees a slot, which keeps 1 beat/clk with m_ready high.
   always_comb begin
      beat_acc  = m_valid && m_ready;
      last_acc  = beat_acc && (out_cnt_q == OUT_LAST);
      start_ok  = en && !fifo_empty;
      can_take  = (3'(occ) + 3'(inflight_q)) < (SKID_CAP + 3'(beat_acc));
      fifo_read = 1'b0;
      state_d   = state_q;
      case (state_q)
         IDLE:    if (start_ok) state_d = BURST;
         BURST:   fifo_read = !fifo_empty && can_take && (iss_cnt_q < ISS_FULL);
         DRAIN: begin
            if (last_acc) begin
               fifo_read = start_ok && can_take;
               state_d   = start_ok ? BURST : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      iss_cnt_d = (state_q == DRAIN && last_acc) ? '0 : iss_cnt_q;
      if (fifo_read) begin
         iss_cnt_d = iss_cnt_d + ISS_W'(1);
      end
      if (state_q == BURST && iss_cnt_d == ISS_FULL) begin
         state_d = DRAIN;
      end

      out_cnt_d = out_cnt_q;
      if (last_acc) begin
         out_cnt_d = '0;
      end else if (beat_acc) begin
         out_cnt_d = out_cnt_q + OUT_W'(1);
      end

      inflight_d = fifo_read;
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q    <= IDLE;
         iss_cnt_q  <= '0;
         out_cnt_q  <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         iss_cnt_q  <= iss_cnt_d;
         out_cnt_q  <= out_cnt_d;
         inflight_q <= inflight_d;
      end
   end

   stream_skid2 #(.W(EW)) u_skid (
      .clk      (clk),
      .rst_     (rst_),
      .in_valid (inflight_q),
      .in_data  (cap_entry),
      .out_ready(m_ready),
      .out_valid(m_valid),
      .out_data (head),
      .occ      (occ)
   );

`ifdef FIFO_BURST_PARITY_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   // Entry layout: {sideband parity, computed parity, data}.
   assign cap_entry = {fifo_parity, ^fifo_data_out, fifo_data_out};
   assign m_data    = head[width-1:0];
   assign m_parity  = head[width];

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (beat_acc && (head[width+1] != head[width]) && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         err_cnt_q <= 8'd0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign parity_err_cnt = err_cnt_q;
`else
   assign cap_entry = fifo_data_out;
   assign m_data    = head;
`endif

   assign m_last = m_valid && (out_cnt_q == OUT_LAST);
   assign busy   = (state_q != IDLE) || (occ != 2'd0) || inflight_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench: FIFO model with 1-cycle read latency, burst scoreboard, directed and random traffic.
module tb_fifo_burst_reader;

   localparam int BL = 4;

   logic        clk = 1'b0;
   logic        rst_;
   logic        en;
   logic        fifo_empty;
   logic [15:0] fifo_data_out;
   logic        fifo_read;
   logic        m_valid;
   logic        m_ready;
   logic [15:0] m_data;
   logic        m_last;
   logic        busy;
`ifdef FIFO_BURST_PARITY_EN
   logic        fifo_parity;
   logic        m_parity;
   logic [7:0]  parity_err_cnt;
`endif

   fifo_burst_reader #(.width(16), .BURST_LEN(BL), .SKID_DEPTH(2)) dut (
      .clk          (clk),
      .rst_         (rst_),
      .en           (en),
      .fifo_empty   (fifo_empty),
      .fifo_data_out(fifo_data_out),
`ifdef FIFO_BURST_PARITY_EN
      .fifo_parity  (fifo_parity),
      .m_parity     (m_parity),
      .parity_err_cnt(parity_err_cnt),
`endif
      .fifo_read    (fifo_read),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_last       (m_last),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        en;
      logic        rdy;
      logic        rd;
      logic        vld;
      logic [15:0] data;
      logic        chk_data;
      logic        last;
      logic        busy;
   } vec_t;

   vec_t        vecs [14];
   logic [15:0] q[$];
   logic        qbad[$];
   logic [15:0] exp_q[$];
   logic        exp_bad[$];
   int          n_chk = 0;
   int          n_pass = 0;
   int          pending = 0;
   int          beat_n = 0;
   int          total_pops = 0;
   int          exp_err = 0;
   bit          prev_stall = 0;
   logic [15:0] prev_data = '0;
   logic        s_read, s_valid, s_last, s_busy;
   logic [15:0] s_data;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
   endtask

   task automatic push(input logic [15:0] w, input logic bad);
      q.push_back(w);
      qbad.push_back(bad);
      exp_q.push_back(w);
      exp_bad.push_back(bad);
      fifo_empty = 1'b0;
   endtask

   // Entered and left in the drive window (#1 after a rising edge); samples at the falling edge.
   task automatic cycle();
      logic        pop, beat, bad;
      logic [15:0] w;
      @(negedge clk);
      s_read = fifo_read; s_valid = m_valid; s_data = m_data; s_last = m_last; s_busy = busy;
      check("read_while_empty", fifo_read && fifo_empty, 0);
      if (!m_valid) check("last_without_valid", m_last, 0);
      if (prev_stall) begin
         check("stall_valid", m_valid, 1);
         check("stall_data", m_data, prev_data);
      end
`ifdef FIFO_BURST_PARITY_EN
      check("parity_err_cnt", parity_err_cnt, exp_err);
`endif
      pop  = fifo_read && !fifo_empty;
      beat = m_valid && m_ready;
      if (beat) begin
         check("beat_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            check("beat_data", m_data, exp_q[0]);
            check("beat_last", m_last, (beat_n % BL) == BL - 1);
`ifdef FIFO_BURST_PARITY_EN
            check("beat_parity", m_parity, ^exp_q[0]);
`endif
            if (exp_bad[0] && exp_err < 255) exp_err++;
            void'(exp_q.pop_front());
            void'(exp_bad.pop_front());
         end
         beat_n++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      @(posedge clk);
      #1;
      if (pop) begin
         w   = q.pop_front();
         bad = qbad.pop_front();
         fifo_data_out = w;
`ifdef FIFO_BURST_PARITY_EN
         fifo_parity = bad ? ~(^w) : ^w;
`endif
         pending++;
         total_pops++;
      end
      if (beat) pending--;
      fifo_empty = (q.size() == 0);
      check("occupancy_le_2", pending <= 2, 1);
   endtask

   task automatic run_until_idle(input string name, input int budget);
      bit done = 0;
      for (int i = 0; i < budget && !done; i++) begin
         cycle();
         done = (exp_q.size() == 0) && !s_busy;
      end
      check(name, done, 1);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_fifo_read"}, fifo_read, 0);
      check({tag, "_m_valid"}, m_valid, 0);
      check({tag, "_m_data"}, m_data, 0);
      check({tag, "_m_last"}, m_last, 0);
      check({tag, "_busy"}, busy, 0);
`ifdef FIFO_BURST_PARITY_EN
      check({tag, "_m_parity"}, m_parity, 0);
      check({tag, "_parity_err_cnt"}, parity_err_cnt, 0);
`endif
   endtask

   initial begin
      int  start_beats, start_pops;
      bit  done;
      // Fields: en, rdy, fifo_read, m_valid, m_data, check data, m_last, busy.
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
      vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
      vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b1};
      vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0003, 1'b1, 1'b0, 1'b1};
      vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0004, 1'b1, 1'b1, 1'b1};
      vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b0, 1'b1};
      vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0006, 1'b1, 1'b0, 1'b1};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0007, 1'b1, 1'b0, 1'b1};
      vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0008, 1'b1, 1'b1, 1'b1};
      vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};

      rst_ = 1'b0; en = 1'b0; m_ready = 1'b1; fifo_empty = 1'b1; fifo_data_out = '0;
`ifdef FIFO_BURST_PARITY_EN
      fifo_parity = 1'b0;
`endif
      for (int i = 1; i <= 8; i++) push(16'(i), i == 3);
      #12;
      check_zero_outputs("reset");
      @(posedge clk); #1;
      rst_ = 1'b1;

      // Two back-to-back bursts of preloaded words, cycle by cycle.
      for (int i = 0; i < 14; i++) begin
         en = vecs[i].en;
         m_ready = vecs[i].rdy;
         cycle();
         check($sformatf("vec%0d_fifo_read", i), s_read, vecs[i].rd);
         check($sformatf("vec%0d_m_valid", i), s_valid, vecs[i].vld);
         check($sformatf("vec%0d_m_last", i), s_last, vecs[i].last);
         check($sformatf("vec%0d_busy", i), s_busy, vecs[i].busy);
         if (vecs[i].chk_data) check($sformatf("vec%0d_m_data", i), s_data, vecs[i].data);
      end
`ifdef FIFO_BURST_PARITY_EN
      check("parity_err_after_w3", parity_err_cnt, 1);
`endif

      // FIFO runs dry mid-burst: stall in BURST, then finish when the 4th word arrives.
      start_beats = beat_n; start_pops = total_pops;
      for (int i = 0; i < 3; i++) push(16'h0011 + 16'(i), 1'b0);
      for (int i = 0; i < 10; i++) cycle();
      check("dry_beats", beat_n - start_beats, 3);
      check("dry_pops", total_pops - start_pops, 3);
      check("dry_busy", s_busy, 1);
      push(16'h0014, 1'b0);
      run_until_idle("dry_resume_idle", 20);
      check("dry_total_beats", beat_n - start_beats, 4);

      // Backpressure pattern 1,0,0,1 with a steady supply.
      for (int i = 0; i < 20; i++) push(16'h0200 + 16'(i), 1'b0);
      done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         m_ready = (i % 4 == 0) || (i % 4 == 3);
         cycle();
         done = (exp_q.size() == 0) && !s_busy;
      end
      check("toggle_drained", done, 1);
      m_ready = 1'b1;

      // en dropped after the 2nd beat: the burst still completes, 12 words stay queued.
      for (int i = 0; i < 16; i++) push(16'h0300 + 16'(i), 1'b0);
      start_beats = beat_n;
      done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         cycle();
         done = (beat_n - start_beats) >= 2;
      end
      check("en_drop_reach2", done, 1);
      en = 1'b0;
      done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         cycle();
         done = !s_busy;
      end
      check("en_drop_idle", done, 1);
      check("en_drop_beats", beat_n - start_beats, 4);
      check("en_drop_left", q.size(), 12);
      en = 1'b1;
      run_until_idle("en_resume_idle", 100);

      // Reset with two words buffered; they and their pops are lost.
      for (int i = 0; i < 8; i++) push(16'h0400 + 16'(i), 1'b0);
      m_ready = 1'b0;
      done = 0;
      for (int i = 0; i < 10 && !done; i++) begin
         cycle();
         done = (pending == 2);
      end
      check("rst_fill_reached", done, 1);
      cycle();
      check("rst_pre_valid", s_valid, 1);
      rst_ = 1'b0;
      #1;
      check_zero_outputs("midrst");
      for (int i = 0; i < pending; i++) begin
         void'(exp_q.pop_front());
         void'(exp_bad.pop_front());
      end
      pending = 0; beat_n = 0; exp_err = 0; prev_stall = 0;
      @(negedge clk); @(posedge clk); #1;
      rst_ = 1'b1;
      m_ready = 1'b1;
      push(16'h0408, 1'b0);
      push(16'h0409, 1'b0);
      run_until_idle("post_rst_idle", 60);
      check("post_rst_beats", beat_n, 8);

      // Random traffic: words arrive in groups of 4 so every burst can complete.
      for (int i = 0; i < 1500; i++) begin
         m_ready = ($urandom_range(0, 3) != 0);
         en = ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 7) == 0 && q.size() < 24) begin
            for (int k = 0; k < 4; k++) push(16'($urandom), $urandom_range(0, 15) == 0);
         end
         cycle();
      end
      en = 1'b1;
      m_ready = 1'b1;
      run_until_idle("random_drain_idle", 400);
      check("random_fifo_empty", q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
